// File: rtl/block_mem_responder.sv
// Memory-side responder for the 128-bit block interface: one latched read or write
// at a time, a fixed access latency, and a level `complete` handshake.
module block_mem_responder #(
   parameter int BLK_W   = 8,
   parameter int LATENCY = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             re,
   input  logic             we,
   input  logic [BLK_W+1:0] addr,
   input  logic [127:0]     din,
   output logic [127:0]     dout,
   output logic             complete,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

   state_t           state;
   logic [7:0]       cnt;
   logic [BLK_W-1:0] idx;
   logic [127:0]     wdata;
   logic             is_write;
   logic             mem_write;
   logic [127:0]     mem [0:(1 << BLK_W) - 1];

   // Word-select bits are irrelevant to a whole-block access.
   logic addr_unused;
   assign addr_unused = ^addr[1:0];

   // The access fires on the last BUSY cycle; state is IDLE while reset is held,
   // so a pending write is dropped by an asynchronous reset.
   assign mem_write = (state == BUSY) && (cnt == 8'd0) && is_write;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= 8'd0;
         idx      <= '0;
         wdata    <= '0;
         is_write <= 1'b0;
         dout     <= '0;
         complete <= 1'b0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (re || we) begin
                  idx      <= addr[BLK_W+1:2];
                  wdata    <= din;
                  is_write <= we;
                  cnt      <= CNT_LOAD;
                  busy     <= 1'b1;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (cnt == 8'd0) begin
                  if (!is_write) begin
                     dout <= mem[idx];
                  end
                  busy     <= 1'b0;
                  complete <= 1'b1;
                  state    <= DONE;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            DONE: begin
               if (!re && !we) begin
                  complete <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: begin
               busy     <= 1'b0;
               complete <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

   // NOTE: the storage array has no reset; it maps onto plain RAM and its
   // contents survive a reset of the control logic.
   always_ff @(posedge clk) begin
      if (mem_write) begin
         mem[idx] <= wdata;
      end
   end

endmodule

// File: tb/tb_block_mem_responder.sv
// Directed bench for block_mem_responder: a reference memory model feeds a queue of
// expected read data that is popped and compared whenever `complete` rises.
module tb_block_mem_responder;

   localparam int LAT = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         re, we, re1, we1;
   logic [9:0]   addr, addr1;
   logic [127:0] din, din1;
   logic [127:0] dout, dout1;
   logic         complete, busy, complete1, busy1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [127:0] ref_mem  [0:255];
   logic [127:0] ref_mem1 [0:255];
   logic [127:0] last_dout  = '0;
   logic [127:0] last_dout1 = '0;
   logic [127:0] exp_q [$];

   block_mem_responder #(.BLK_W(8), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .re(re), .we(we), .addr(addr), .din(din),
      .dout(dout), .complete(complete), .busy(busy)
   );

   block_mem_responder #(.BLK_W(8), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .re(re1), .we(we1), .addr(addr1), .din(din1),
      .dout(dout1), .complete(complete1), .busy(busy1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; returns at a falling edge with the request released.
   task automatic access(input logic r, input logic w, input logic [9:0] a,
                         input logic [127:0] d, input int hold, input logic mutate);
      int n;
      re = r; we = w; addr = a; din = d;
      if (w) ref_mem[a[9:2]] = d;
      else   last_dout = ref_mem[a[9:2]];
      exp_q.push_back(last_dout);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) check("busy_after_accept", 128'(busy), 128'(1));
         if (mutate && n == 2) begin
            addr = 10'h020;
            din  = '0;
         end
      end while (!complete && n < 20);
      check("complete_latency", 128'(n), 128'(LAT + 1));
      check("dout_at_complete", dout, exp_q.pop_front());
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("complete_held", 128'(complete), 128'(1));
         check("busy_in_done", 128'(busy), 128'(0));
      end
      re = 1'b0; we = 1'b0;
      @(negedge clk);
      check("complete_falls", 128'(complete), 128'(0));
   endtask

   task automatic access1(input logic r, input logic w, input logic [9:0] a,
                          input logic [127:0] d, output int acc_cyc);
      int n;
      re1 = r; we1 = w; addr1 = a; din1 = d;
      if (w) ref_mem1[a[9:2]] = d;
      else   last_dout1 = ref_mem1[a[9:2]];
      exp_q.push_back(last_dout1);
      n = 0;
      acc_cyc = -1;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            acc_cyc = cyc;
            check("l1_busy_after_accept", 128'(busy1), 128'(1));
         end
      end while (!complete1 && n < 20);
      check("l1_complete_latency", 128'(n), 128'(2));
      check("l1_dout_at_complete", dout1, exp_q.pop_front());
      re1 = 1'b0; we1 = 1'b0;
      @(negedge clk);
      check("l1_complete_falls", 128'(complete1), 128'(0));
   endtask

   initial begin
      int acc_a, acc_b, acc_c;
      rst = 1'b0;
      re = 1'b0; we = 1'b0; addr = '0; din = '0;
      re1 = 1'b0; we1 = 1'b0; addr1 = '0; din1 = '0;

      @(negedge clk);
      check("rst_complete", 128'(complete), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_dout", dout, '0);
      check("rst_l1_complete", 128'(complete1), 128'(0));
      check("rst_l1_busy", 128'(busy1), 128'(0));
      check("rst_l1_dout", dout1, '0);
      rst = 1'b1;
      @(negedge clk);

      // Basic write then read of block 1 through a different word offset.
      access(1'b0, 1'b1, 10'h004, 128'h44443333_22221111_0000FFFF_DEADBEEF, 0, 1'b0);
      access(1'b1, 1'b0, 10'h007, '0, 0, 1'b0);

      // Address-range ends.
      access(1'b0, 1'b1, 10'h3FC, {16{8'hA5}}, 0, 1'b0);
      access(1'b0, 1'b1, 10'h000, {16{8'h5A}}, 0, 1'b0);
      access(1'b1, 1'b0, 10'h3FC, '0, 0, 1'b0);
      access(1'b1, 1'b0, 10'h000, '0, 0, 1'b0);

      // Simultaneous read+write behaves as a write and leaves dout alone.
      access(1'b0, 1'b1, 10'h018, 128'h1234, 0, 1'b0);
      access(1'b1, 1'b0, 10'h018, '0, 0, 1'b0);
      access(1'b1, 1'b1, 10'h010, {128{1'b1}}, 0, 1'b0);
      access(1'b1, 1'b0, 10'h010, '0, 0, 1'b0);

      // Inputs changed during BUSY are ignored; a held request is not re-accepted.
      access(1'b0, 1'b1, 10'h020, {16{8'hC3}}, 0, 1'b0);
      access(1'b0, 1'b1, 10'h00C, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 0, 1'b1);
      access(1'b1, 1'b0, 10'h00C, '0, 5, 1'b0);
      access(1'b1, 1'b0, 10'h020, '0, 0, 1'b0);

      // Asynchronous reset in the middle of a write.
      access(1'b0, 1'b1, 10'h008, {16{8'h77}}, 0, 1'b0);
      access(1'b1, 1'b0, 10'h008, '0, 0, 1'b0);
      re = 1'b0; we = 1'b1; addr = 10'h008; din = {16{8'h11}};
      @(negedge clk);
      check("busy_before_reset", 128'(busy), 128'(1));
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("async_rst_complete", 128'(complete), 128'(0));
      check("async_rst_busy", 128'(busy), 128'(0));
      check("async_rst_dout", dout, '0);
      we = 1'b0;
      last_dout = '0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      access(1'b1, 1'b0, 10'h008, '0, 0, 1'b0);

      // Single-cycle latency build, back-to-back requests.
      access1(1'b0, 1'b1, 10'h014, 128'hCAFEF00D_01234567_89ABCDEF_FEEDFACE, acc_a);
      access1(1'b1, 1'b0, 10'h014, '0, acc_b);
      access1(1'b1, 1'b0, 10'h015, '0, acc_c);
      check("l1_spacing_ab", 128'(acc_b - acc_a), 128'(3));
      check("l1_spacing_bc", 128'(acc_c - acc_b), 128'(3));
      check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/block_mem_responder.md
# block_mem_responder

Memory-side responder for the 128-bit block interface driven by the L1 cache FSM. It accepts one block read or block write request at a time, models a fixed multi-cycle DRAM access latency with an internal countdown, and signals completion with a level handshake on `complete`. It sits below the cache, in place of the behavioural DRAM model, and backs 2^BLK_W blocks of four 32-bit words each.

## Interface
- `BLK_W`, 8: block-index width; capacity is 2^BLK_W blocks of 128 bits.
- `LATENCY`, 4: cycles from request acceptance to `complete`; legal range 1..255.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `re`  in  1  block read request, level, held until `complete` is seen.
- `we`  in  1  block write request, level, held until `complete` is seen.
- `addr`  in  BLK_W+2  word address; `addr[BLK_W+1:2]` selects the block and `addr[1:0]` is ignored.
- `din`  in  128  write block; word 0 in bits [31:0], word 3 in bits [127:96].
- `dout`  out  128  read block, registered, same word order as `din`.
- `complete`  out  1  access finished; level, registered.
- `busy`  out  1  a request is latched and not yet completed.

## Operation
- FSM has 3 states.
  - IDLE: `busy`=0, `complete`=0. On `re|we`, latch the block index, `din`, and the operation, then load the counter with LATENCY-1 and go to BUSY.
  - BUSY: `busy`=1. Decrement the counter each cycle. When the counter is 0, perform the access and go to DONE.
  - DONE: `complete`=1, `busy`=0. Stay while `re|we` is high. When both are low, return to IDLE and drop `complete` the same edge.
- Read access: `dout` <= mem[latched index]. `dout` holds its value until the next read completes; writes never change it.
- Write access: mem[latched index] <= latched `din`. The whole 128-bit block is written; there is no partial-word write.
- `we` and `re` both high at acceptance: the operation is a write. `dout` is unchanged.
- Changes to `addr`, `din`, `re`, or `we` while in BUSY are ignored, because the request is latched. Dropping the request in BUSY does not abort the access; the FSM still reaches DONE and then exits it immediately if the request stays low.
- A new request seen in DONE is not a new access. The requester must drop both `re` and `we` for at least one cycle between requests.
- The counter is 8 bits. LATENCY=1 loads 0, so the access happens on the first BUSY cycle.
- Storage has no reset. Its contents are undefined until written, and a reset does not clear them.

## Timing
- Reset values: state IDLE, counter 0, `complete`=0, `busy`=0, `dout`=128'b0.
- Reset asserted mid-access: the FSM goes to IDLE immediately and asynchronously. A pending write is discarded (memory unchanged) and a pending read leaves `dout` at 0.
- Request sampled high at edge N (FSM in IDLE): `busy`=1 after edge N, and `complete`=1 after edge N+LATENCY.
  - Read data is valid on `dout` in the same cycle `complete` rises.
  - A write is visible to a read accepted on any later edge.
- `complete` falls after the first edge at which `re` and `we` are both sampled low. The minimum request-to-request period is therefore LATENCY+2 cycles.
- There is no combinational path from any input to any output.

## Test plan
- Reset, then write: `we`=1, `addr`=0x004 (block 1), `din`=0x44443333_22221111_0000FFFF_DEADBEEF, LATENCY=4. `complete` must rise exactly 4 cycles after acceptance; release `we`. Then read `addr`=0x007. `dout` must equal that pattern when `complete` rises, and `complete` must fall one cycle after `re` drops.
- Write block 255 (`addr`=0x3FC) with 0xA5 repeated, then block 0 with 0x5A repeated. Read both back: each returns its own pattern, with no aliasing at the address wrap.
- Simultaneous request: `re`=`we`=1, `addr`=0x010, `din`=all-ones, after an earlier read left `dout`=0x1234. `dout` must stay 0x1234; a following read of block 4 returns all-ones.
- Change `addr` to 0x020 and `din` to 0 two cycles into a write of block 3. Block 3 gets the original data and block 8 is unchanged. Then hold `re` for 5 extra cycles after `complete`: `complete` stays high and no second access occurs (`busy` stays 0).
- Assert `rst`=0 for one cycle during BUSY of a write to block 2 (pre-filled with 0x77). `complete`, `busy`, and `dout` go to 0 at once. A later read of block 2 returns 0x77 in every byte.
- LATENCY=1 build: read accepted at edge N gives `complete`=1 after edge N+1 with correct data, and back-to-back requests are spaced 3 cycles apart.
